// File: rtl/decoder3x8_strobe.sv
// decoder3x8_strobe: sequential 3-to-8 decoder.
// Codes arrive over valid/ready and are buffered in a small FIFO. Each code
// is replayed as a one-hot strobe for HOLD cycles. The strobe is followed by
// GAP idle cycles, during which out is zero.
module decoder3x8_strobe #(
  parameter int HOLD  = 4,   // cycles each one-hot pattern is held (>= 1)
  parameter int GAP   = 1,   // zero cycles after each hold (>= 0)
  parameter int DEPTH = 4    // FIFO entries (power of 2, >= 2)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : {CNT_W{1'b0}};
  localparam bit               HAS_GAP   = (GAP > 0);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   FCNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FCNT_ZERO = {(PTR_W + 1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Binary code to one-hot strobe. Every 3-bit value maps to exactly one bit.
  function automatic logic [7:0] decode_onehot(input logic [2:0] code);
    logic [7:0] pat;
    case (code)
      3'd0:    pat = 8'b0000_0001;
      3'd1:    pat = 8'b0000_0010;
      3'd2:    pat = 8'b0000_0100;
      3'd3:    pat = 8'b0000_1000;
      3'd4:    pat = 8'b0001_0000;
      3'd5:    pat = 8'b0010_0000;
      3'd6:    pat = 8'b0100_0000;
      3'd7:    pat = 8'b1000_0000;
      default: pat = 8'b0000_0000;
    endcase
    return pat;
  endfunction

  // FIFO state
  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // FSM / output state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [2:0]       head_s;

  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  assign full_s   = (count_q == CNT_FULL);
  assign empty_s  = (count_q == FCNT_ZERO);
  assign push_s   = in_valid && !full_s;
  assign head_s   = mem_q[rd_ptr_q];

  assign in_ready  = !full_s;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE) || (count_q != FCNT_ZERO);

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + FCNT_ONE;
      2'b01:   count_d = count_q - FCNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state: load, hold, gap, and return to idle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          out_d       = decode_onehot(head_s);
          out_valid_d = 1'b1;
          cnt_d       = HOLD_LOAD;
          state_d     = ST_DRIVE;
        end else begin
          out_d       = 8'h00;
          out_valid_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (HAS_GAP) begin
          out_d       = 8'h00;
          out_valid_d = 1'b0;
          cnt_d       = GAP_LOAD;
          state_d     = ST_GAP;
        end else if (!empty_s) begin
          // With no gap, the next pattern follows immediately.
          pop_s       = 1'b1;
          out_d       = decode_onehot(head_s);
          out_valid_d = 1'b1;
          cnt_d       = HOLD_LOAD;
          state_d     = ST_DRIVE;
        end else begin
          out_d       = 8'h00;
          out_valid_d = 1'b0;
          cnt_d       = CNT_ZERO;
          state_d     = ST_IDLE;
        end
      end
      ST_GAP: begin
        out_d       = 8'h00;
        out_valid_d = 1'b0;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!empty_s) begin
          pop_s       = 1'b1;
          out_d       = decode_onehot(head_s);
          out_valid_d = 1'b1;
          cnt_d       = HOLD_LOAD;
          state_d     = ST_DRIVE;
        end else begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end
      default: begin
        out_d       = 8'h00;
        out_valid_d = 1'b0;
        cnt_d       = CNT_ZERO;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // FIFO storage and pointers. Reset discards every queued code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 3'd0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= FCNT_ZERO;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_code;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer state, hold/gap counter and registered strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_decoder3x8_strobe.sv
// Testbench for decoder3x8_strobe.
// Instance A uses HOLD=4, GAP=1, DEPTH=4. Instance B uses HOLD=1, GAP=0, DEPTH=4.
// Accepted codes are queued as expected strobes. Per-instance monitors pop
// each queue and compare against what appears on out.
module tb_decoder3x8_strobe;

  localparam int HOLD_A = 4;
  localparam int GAP_A  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in_valid, b_in_valid;
  logic [2:0] a_in_code,  b_in_code;
  logic       a_in_ready, b_in_ready;
  logic [7:0] a_out,      b_out;
  logic       a_out_valid, b_out_valid;
  logic       a_busy,     b_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  // Hand-written one-hot table, indexed by code.
  logic [7:0] lut [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  always #5 clk = ~clk;

  decoder3x8_strobe #(.HOLD(HOLD_A), .GAP(GAP_A), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_code(a_in_code),
    .in_ready(a_in_ready), .out(a_out), .out_valid(a_out_valid), .busy(a_busy)
  );

  decoder3x8_strobe #(.HOLD(1), .GAP(0), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_code(b_in_code),
    .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Offer code c to A and hold it until accepted. While in_ready is low,
  // drive a different code so that a refused push would show up as a
  // corrupted pattern. Returns at the negedge after the accepting edge.
  task automatic push_a(input logic [2:0] c, output int stalls);
    logic rdy;
    int   guard;
    stalls = 0;
    guard  = 0;
    a_in_valid = 1'b1;
    forever begin
      rdy = a_in_ready;
      a_in_code = rdy ? c : (c ^ 3'b101);
      @(negedge clk);
      if (rdy) begin
        exp_a.push_back(lut[c]);
        break;
      end
      stalls++;
      guard++;
      if (guard > 200) begin
        n_fail++;
        $display("FAIL push_timeout: code %0d not accepted after %0d cycles", c, guard);
        break;
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int k;
    k = 0;
    while ((a_busy || exp_a.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain_a", (a_busy || exp_a.size() != 0), 0);
  endtask

  // Monitor A: pattern order, hold length, gap length, and output invariants
  logic [7:0] prev_out_a;
  bit         prev_v_a  = 1'b0;
  bit         gap_chk_a = 1'b0;
  int         run_a     = 0;
  int         zrun_a    = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v_a   = 1'b0;
      gap_chk_a  = 1'b0;
      run_a      = 0;
      zrun_a     = 0;
      prev_out_a = 8'h00;
    end else begin
      check("onehot_a", ($countones(a_out) <= 1), 1);
      check("valid_eq_a", a_out_valid, (a_out != 8'h00));
      if (a_out_valid) begin
        if (prev_v_a && a_out == prev_out_a && run_a < HOLD_A) begin
          run_a++;
        end else begin
          if (prev_v_a) check("hold_len_a", run_a, HOLD_A);
          else if (gap_chk_a) check("gap_len_a", zrun_a, GAP_A);
          if (exp_a.size() == 0) check("unexpected_a", a_out, 8'h00);
          else check("pattern_a", a_out, exp_a.pop_front());
          run_a     = 1;
          zrun_a    = 0;
          gap_chk_a = 1'b0;
        end
      end else begin
        if (prev_v_a) begin
          check("hold_len_a", run_a, HOLD_A);
          gap_chk_a = (exp_a.size() != 0);
          zrun_a    = 1;
        end else begin
          zrun_a++;
        end
      end
      prev_v_a   = a_out_valid;
      prev_out_a = a_out;
    end
  end

  // Monitor B: one pattern per valid cycle, no zero cycle while codes are pending
  bit prev_v_b = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v_b = 1'b0;
    end else begin
      check("onehot_b", ($countones(b_out) <= 1), 1);
      if (b_out_valid) begin
        if (exp_b.size() == 0) check("unexpected_b", b_out, 8'h00);
        else check("pattern_b", b_out, exp_b.pop_front());
      end else if (prev_v_b) begin
        check("no_gap_b", exp_b.size(), 0);
      end
      prev_v_b = b_out_valid;
    end
  end

  initial begin
    int st;
    rst        = 1'b1;
    a_in_valid = 1'b0;
    a_in_code  = 3'd0;
    b_in_valid = 1'b0;
    b_in_code  = 3'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_a", a_out, 8'h00);
    check("rst_out_valid_a", a_out_valid, 0);
    check("rst_in_ready_a", a_in_ready, 1);
    check("rst_busy_a", a_busy, 0);
    check("rst_out_b", b_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Single code 3: 08 for four cycles, one zero cycle, then idle
    push_a(3'd3, st);
    check("single_pre_out", a_out, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_out", a_out, 8'h08);
      check("single_busy", a_busy, 1);
    end
    @(negedge clk);
    check("single_gap_out", a_out, 8'h00);
    check("single_gap_busy", a_busy, 1);
    @(negedge clk);
    check("single_idle_busy", a_busy, 0);

    // All eight codes back to back
    for (int c = 0; c < 8; c++) begin
      push_a(3'(c), st);
    end
    drain_a();

    // FIFO full: one code on out, four queued, fifth waits for a pop
    push_a(3'd1, st);
    for (int c = 2; c < 6; c++) begin
      push_a(3'(c), st);
    end
    check("full_ready", a_in_ready, 0);
    push_a(3'd6, st);
    check("full_stalls", st, 2);
    drain_a();

    // Reset mid-DRIVE with code 6 on out and two codes queued
    push_a(3'd6, st);
    push_a(3'd1, st);
    push_a(3'd2, st);
    check("pre_rst_out", a_out, 8'h40);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", a_out, 8'h00);
    check("mid_rst_out_valid", a_out_valid, 0);
    check("mid_rst_in_ready", a_in_ready, 1);
    check("mid_rst_busy", a_busy, 0);
    exp_a.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", a_busy, 0);
    check("post_rst_out", a_out, 8'h00);

    // Continuous output on B: 5,2,7 -> 20,04,80 with no zero between
    b_in_valid = 1'b1;
    b_in_code  = 3'd5;
    @(negedge clk);
    check("cont_ready", b_in_ready, 1);
    check("cont_out0", b_out, 8'h00);
    exp_b.push_back(8'h20);
    b_in_code = 3'd2;
    @(negedge clk);
    check("cont_out1", b_out, 8'h20);
    exp_b.push_back(8'h04);
    b_in_code = 3'd7;
    @(negedge clk);
    check("cont_out2", b_out, 8'h04);
    exp_b.push_back(8'h80);
    b_in_valid = 1'b0;
    @(negedge clk);
    check("cont_out3", b_out, 8'h80);
    @(negedge clk);
    check("cont_out4", b_out, 8'h00);
    @(negedge clk);
    check("cont_busy_b", b_busy, 0);

    check("leftover_a", exp_a.size(), 0);
    check("leftover_b", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
